// File: rtl/ocram_bist_master.sv
`default_nettype none
// ============================================================================
// Module   : ocram_bist_master
// Purpose  : Write/read-back self-test master for an on-chip RAM slave.
//            Optional error log enabled by macro OCRAM_BIST_ERRLOG_EN.
// Revision : 1.0 - initial release
// ============================================================================
module ocram_bist_master #(
    parameter int ADDR_W       = 10,
    parameter int NUM_WORDS    = 1024,
    parameter int READ_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [31:0]       seed,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [15:0]       err_count,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic [ADDR_W-1:0] avm_address,
    output logic [3:0]        avm_byteenable,
    output logic              avm_chipselect,
    output logic              avm_write,
    output logic [31:0]       avm_writedata,
    input  logic [31:0]       avm_readdata,
    input  logic              avm_waitrequest
);

    typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_t;

    localparam logic [ADDR_W-1:0]       LAST_ADDR = ADDR_W'(NUM_WORDS - 1);
    localparam logic [READ_LATENCY-1:0] OUT_BIT   = READ_LATENCY'(1) << (READ_LATENCY - 1);

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_seed;
    logic [READ_LATENCY-1:0] r_pv;
    logic [ADDR_W-1:0] r_pa [READ_LATENCY];
    logic              r_mismatch_seen;
    logic              r_pass;

    logic w_start_ok;
    logic w_accept;
    logic w_last;
    logic w_rd_accept;
    logic w_cmp_valid;
    logic w_mismatch;
    logic w_pending;

    function automatic logic [31:0] pattern(input logic [31:0] s, input logic [ADDR_W-1:0] a);
        return s ^ {6'b0, 10'(a), 6'b0, 10'(a)};
    endfunction

    assign w_start_ok  = (r_state == IDLE) && start;
    assign w_accept    = ((r_state == WRITE) || (r_state == READ)) && !avm_waitrequest;
    assign w_rd_accept = (r_state == READ) && !avm_waitrequest;
    assign w_last      = (r_addr == LAST_ADDR);
    assign w_cmp_valid = r_pv[READ_LATENCY-1];
    assign w_mismatch  = w_cmp_valid && (avm_readdata != pattern(r_seed, r_pa[READ_LATENCY-1]));
    // Entries still in flight excluding the one being compared this cycle
    assign w_pending   = |(r_pv & ~OUT_BIT);

    assign done = (r_state == DONE);
    assign pass = r_pass;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next         = r_state;
        busy           = 1'b1;
        avm_chipselect = 1'b0;
        avm_write      = 1'b0;
        avm_address    = '0;
        avm_writedata  = '0;
        avm_byteenable = 4'h0;
        case (r_state)
            IDLE: begin
                busy = 1'b0;
                if (start) w_next = WRITE;
            end
            WRITE: begin
                avm_chipselect = 1'b1;
                avm_write      = 1'b1;
                avm_address    = r_addr;
                avm_writedata  = pattern(r_seed, r_addr);
                avm_byteenable = 4'hF;
                if (w_accept && w_last) w_next = READ;
            end
            READ: begin
                avm_chipselect = 1'b1;
                avm_address    = r_addr;
                avm_byteenable = 4'hF;
                if (w_accept && w_last) w_next = DRAIN;
            end
            DRAIN: begin
                if (!w_pending) w_next = DONE;
            end
            DONE: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_addr <= '0;
            r_seed <= '0;
        end else if (w_start_ok) begin
            r_addr <= '0;
            r_seed <= seed;
        end else if (w_accept) begin
            r_addr <= w_last ? '0 : r_addr + ADDR_W'(1);
        end
    end

    // Read-return tracker: each stage carries {valid, address} of an accepted read
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pv <= '0;
            for (int i = 0; i < READ_LATENCY; i++) r_pa[i] <= '0;
        end else begin
            r_pv[0] <= w_rd_accept;
            r_pa[0] <= r_addr;
            for (int i = 1; i < READ_LATENCY; i++) begin
                r_pv[i] <= r_pv[i-1];
                r_pa[i] <= r_pa[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mismatch_seen <= 1'b0;
            r_pass          <= 1'b0;
        end else if (w_start_ok) begin
            r_mismatch_seen <= 1'b0;
            r_pass          <= 1'b0;
        end else begin
            if (w_mismatch) r_mismatch_seen <= 1'b1;
            // The final compare can land in the last DRAIN cycle, so fold it in here
            if ((r_state == DRAIN) && (w_next == DONE))
                r_pass <= !(r_mismatch_seen || w_mismatch);
        end
    end

`ifdef OCRAM_BIST_ERRLOG_EN
    logic [15:0]       r_err_count;
    logic [ADDR_W-1:0] r_first_err_addr;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_err_count      <= '0;
            r_first_err_addr <= '0;
        end else if (w_start_ok) begin
            r_err_count      <= '0;
            r_first_err_addr <= '0;
        end else if (w_mismatch) begin
            if (r_err_count != 16'hFFFF) r_err_count <= r_err_count + 16'd1;
            if (!r_mismatch_seen) r_first_err_addr <= r_pa[READ_LATENCY-1];
        end
    end

    assign err_count      = r_err_count;
    assign first_err_addr = r_first_err_addr;
`else
    assign err_count      = '0;
    assign first_err_addr = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ocram_bist_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_ocram_bist_master
// Purpose  : Self-checking bench with a RAM slave model for ocram_bist_master.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ocram_bist_master;

    localparam int AW = 10;
    localparam int NW = 1024;
`ifdef OCRAM_BIST_ERRLOG_EN
    localparam bit ERRLOG = 1'b1;
`else
    localparam bit ERRLOG = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset_n, start;
    logic [31:0]   seed;
    logic          busy, done, pass;
    logic [15:0]   err_count;
    logic [AW-1:0] first_err_addr, avm_address;
    logic [3:0]    avm_byteenable;
    logic          avm_chipselect, avm_write, avm_waitrequest;
    logic [31:0]   avm_writedata, avm_readdata;

    logic          start3, busy3, done3, pass3, cs3, wr3, waitreq3;
    logic [31:0]   seed3, wd3, readdata3;
    logic [15:0]   err_count3;
    logic [AW-1:0] first3, addr3;
    logic [3:0]    be3;

    ocram_bist_master #(.ADDR_W(AW), .NUM_WORDS(NW), .READ_LATENCY(1)) u_dut (
        .clk(clk), .reset_n(reset_n), .start(start), .seed(seed),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .first_err_addr(first_err_addr), .avm_address(avm_address),
        .avm_byteenable(avm_byteenable), .avm_chipselect(avm_chipselect),
        .avm_write(avm_write), .avm_writedata(avm_writedata),
        .avm_readdata(avm_readdata), .avm_waitrequest(avm_waitrequest)
    );

    ocram_bist_master #(.ADDR_W(AW), .NUM_WORDS(NW), .READ_LATENCY(3)) u_dut3 (
        .clk(clk), .reset_n(reset_n), .start(start3), .seed(seed3),
        .busy(busy3), .done(done3), .pass(pass3), .err_count(err_count3),
        .first_err_addr(first3), .avm_address(addr3),
        .avm_byteenable(be3), .avm_chipselect(cs3),
        .avm_write(wr3), .avm_writedata(wd3),
        .avm_readdata(readdata3), .avm_waitrequest(waitreq3)
    );

    // RAM slave model, read latency 1, with optional bit-0 faults and a write stall
    logic [31:0] mem [NW];
    logic [31:0] rdata_q = 32'h0;
    int fault_a = -1, fault_b = -1, stall_addr = -1, stall_cnt = 0;

    assign avm_waitrequest = avm_chipselect && avm_write &&
                             (int'(avm_address) == stall_addr) && (stall_cnt < 3);
    assign avm_readdata = rdata_q;

    always @(posedge clk) begin
        if (start) stall_cnt <= 0;
        else if (avm_waitrequest) stall_cnt <= stall_cnt + 1;
        if (avm_chipselect && avm_write && !avm_waitrequest)
            mem[avm_address] <= avm_writedata;
        if (avm_chipselect && !avm_write && !avm_waitrequest)
            rdata_q <= mem[avm_address] ^ {31'b0, (int'(avm_address) == fault_a) ||
                                                  (int'(avm_address) == fault_b)};
    end

    typedef struct {
        logic [31:0] seed;
        int fa; int fb; int sa;
        bit pass; int errs; int first; int cycles;
    } vec_t;

    typedef struct {
        bit            pass;
        logic [15:0]   errs;
        logic [AW-1:0] first;
        int            cycles;
    } exp_t;

    exp_t sb[$];

    int n_checks = 0;
    int n_errs   = 0;
    int cyc      = 0;
    int done_cnt = 0;
    logic [31:0] cur_seed = 32'h0;
    logic [31:0] w5 = 32'h0;

    function automatic logic [31:0] exp_pat(input logic [31:0] s, input int a);
        logic [9:0] a10;
        a10 = 10'(a);
        return s ^ {6'd0, a10, 6'd0, a10};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%08h, want 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (done) done_cnt++;
        if (avm_chipselect) chk("byteenable", 32'(avm_byteenable), 32'hF);
        if (!busy || done) chk("cs_when_idle", 32'(avm_chipselect), 32'h0);
        if (avm_chipselect && avm_write && !avm_waitrequest) begin
            chk("writedata", avm_writedata, exp_pat(cur_seed, int'(avm_address)));
            if (int'(avm_address) == 5) w5 = avm_writedata;
        end
        if (avm_waitrequest) begin
            chk("stall_addr", 32'(avm_address), 32'(stall_addr));
            chk("stall_data", avm_writedata, exp_pat(cur_seed, stall_addr));
        end
    endtask

    task automatic check_result();
        exp_t e;
        if (!done) begin
            n_checks++;
            n_errs++;
            $display("FAIL timeout: no done after %0d cycles", cyc);
        end
        e = sb.pop_front();
        chk("done_cycle", 32'(cyc), 32'(e.cycles));
        chk("pass", 32'(pass), 32'(e.pass));
        chk("err_count", 32'(err_count), 32'(e.errs));
        chk("first_err_addr", 32'(first_err_addr), 32'(e.first));
        tick();
        chk("done_one_cycle", 32'(done), 32'h0);
        chk("busy_after_done", 32'(busy), 32'h0);
        chk("pass_hold", 32'(pass), 32'(e.pass));
        repeat (3) tick();
        chk("done_count", 32'(done_cnt), 32'h1);
    endtask

    task automatic run_test(input vec_t v);
        exp_t e;
        fault_a    = v.fa;
        fault_b    = v.fb;
        stall_addr = v.sa;
        cur_seed   = v.seed;
        e.pass   = v.pass;
        e.errs   = ERRLOG ? 16'(v.errs) : 16'd0;
        e.first  = ERRLOG ? AW'(v.first) : '0;
        e.cycles = v.cycles;
        sb.push_back(e);
        @(negedge clk);
        seed     = v.seed;
        start    = 1'b1;
        cyc      = 0;
        done_cnt = 0;
        tick();
        start = 1'b0;
        chk("busy_after_start", 32'(busy), 32'h1);
        while (!done && cyc < 3000) tick();
        check_result();
    endtask

    initial begin
        vec_t vt[5];
        exp_t e;
        int   nz, first_nz, drain3;

        reset_n = 1'b0; start = 1'b0; seed = '0;
        start3 = 1'b0; seed3 = '0; readdata3 = '0; waitreq3 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_pass", 32'(pass), 32'h0);
        chk("rst_cs", 32'(avm_chipselect), 32'h0);
        chk("rst_write", 32'(avm_write), 32'h0);
        chk("rst_addr", 32'(avm_address), 32'h0);
        chk("rst_err_count", 32'(err_count), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;

        vt[0] = '{32'h0000_0000, -1,  -1,  -1, 1'b1, 0, 0,    2050};
        vt[1] = '{32'h0000_0000,  7, 300,  -1, 1'b0, 2, 7,    2050};
        vt[2] = '{32'h0000_0000, -1,  -1,  10, 1'b1, 0, 0,    2053};
        vt[3] = '{32'hA5A5_A5A5,  0, 1023, -1, 1'b0, 2, 0,    2050};
        vt[4] = '{32'h1234_5678, 1023, -1, -1, 1'b0, 1, 1023, 2050};
        for (int i = 0; i < 5; i++) begin
            run_test(vt[i]);
            if (i == 0) chk("pattern_at_5", w5, 32'h0005_0005);
        end

        // Abort mid-write with reset, then a fresh run
        cur_seed = 32'h1111_2222; fault_a = -1; fault_b = -1; stall_addr = -1;
        @(negedge clk);
        seed = cur_seed; start = 1'b1; cyc = 0; done_cnt = 0;
        tick();
        start = 1'b0;
        while (cyc < 600) tick();
        reset_n = 1'b0;
        #1;
        chk("abort_cs", 32'(avm_chipselect), 32'h0);
        chk("abort_busy", 32'(busy), 32'h0);
        chk("abort_write", 32'(avm_write), 32'h0);
        chk("abort_addr", 32'(avm_address), 32'h0);
        chk("abort_wdata", avm_writedata, 32'h0);
        repeat (4) tick();
        chk("abort_no_done", 32'(done_cnt), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        run_test('{32'hA5A5_A5A5, -1, -1, -1, 1'b1, 0, 0, 2050});

        // Stray start with a different seed during READ must be ignored
        cur_seed = 32'h0F0F_F0F0;
        e = '{1'b1, 16'd0, '0, 2050};
        sb.push_back(e);
        @(negedge clk);
        seed = cur_seed; start = 1'b1; cyc = 0; done_cnt = 0;
        tick();
        start = 1'b0;
        while (cyc < 1500) tick();
        seed = 32'hDEAD_BEEF; start = 1'b1;
        tick();
        start = 1'b0; seed = 32'h0;
        chk("stray_start_busy", 32'(busy), 32'h1);
        while (!done && cyc < 3000) tick();
        check_result();

        // READ_LATENCY=3 against a stuck-at-0 slave
        nz = 0; first_nz = -1;
        for (int a = 0; a < NW; a++) begin
            if (exp_pat(32'h0, a) != 32'h0) begin
                nz++;
                if (first_nz < 0) first_nz = a;
            end
        end
        @(negedge clk);
        seed3 = 32'h0; start3 = 1'b1;
        @(posedge clk);
        #1;
        start3 = 1'b0; cyc = 1; drain3 = 0;
        while (!done3 && cyc < 3000) begin
            @(posedge clk);
            #1;
            cyc++;
            if (busy3 && !cs3 && !done3) drain3++;
            if (cs3) chk("rl3_byteenable", 32'(be3), 32'hF);
            if (cs3 && wr3) chk("rl3_writedata", wd3, exp_pat(32'h0, int'(addr3)));
        end
        chk("rl3_done_cycle", 32'(cyc), 32'd2052);
        chk("rl3_drain_len", 32'(drain3), 32'd3);
        chk("rl3_pass", 32'(pass3), 32'h0);
        chk("rl3_err_count", 32'(err_count3), ERRLOG ? 32'(nz) : 32'h0);
        chk("rl3_first_err", 32'(first3), ERRLOG ? 32'(first_nz) : 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
